// File: rtl/shift_unit.sv
// Multi-cycle shifter: SLL/SRL/SRA/ROL/ROR by up to STEP bits per clock,
// with a busy/done handshake and a result held until the next completion.
module shift_unit #(
  parameter int DATA_W = 32,
  parameter int AMT_W  = 5,
  parameter int STEP   = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [1:0]        src_sel,
  input  logic [2:0]        mode,
  input  logic [DATA_W-1:0] data_in,
  input  logic [AMT_W-1:0]  reg_b_amt,
  input  logic [AMT_W-1:0]  shamt,
  input  logic [31:0]       ext_offset,
  output logic [DATA_W-1:0] result,
  output logic              busy,
  output logic              done
);

  typedef enum logic {IDLE, SHIFT} state_t;

  localparam logic [2:0] M_SLL = 3'd0;
  localparam logic [2:0] M_SRL = 3'd1;
  localparam logic [2:0] M_SRA = 3'd2;
  localparam logic [2:0] M_ROL = 3'd3;
  localparam logic [2:0] M_ROR = 3'd4;

  localparam logic [AMT_W:0] STEP_V = (AMT_W+1)'(STEP);
  localparam logic [AMT_W:0] WIDTH_V = (AMT_W+1)'(DATA_W);

  typedef struct packed {
    logic [2:0]        mode;
    logic [AMT_W-1:0]  amt;
    logic [DATA_W-1:0] data;
  } req_t;

  state_t            state;
  logic [2:0]        mode_q;
  logic [AMT_W-1:0]  remaining;
  logic [DATA_W-1:0] work;
  req_t              req;
  logic [AMT_W-1:0]  k;
  logic [AMT_W:0]    k_inv;
  logic [DATA_W-1:0] stepped;
  logic              unused_ext;

  // Only the low AMT_W bits of the offset form an amount.
  assign unused_ext = ^ext_offset[31:AMT_W];

  always_comb begin
    req.mode = mode;
    req.data = data_in;
    case (src_sel)
      2'd0:    req.amt = reg_b_amt;
      2'd1:    req.amt = shamt;
      2'd2:    req.amt = ext_offset[AMT_W-1:0];
      default: req.amt = '0;
    endcase
    if (mode > M_ROR) req.amt = '0;
  end

  // k = min(STEP, remaining); k_inv is the complementary rotate distance.
  assign k     = ({1'b0, remaining} > STEP_V) ? STEP_V[AMT_W-1:0] : remaining;
  assign k_inv = WIDTH_V - {1'b0, k};

  always_comb begin
    case (mode_q)
      M_SLL:   stepped = work << k;
      M_SRL:   stepped = work >> k;
      M_SRA:   stepped = $signed(work) >>> k;
      M_ROL:   stepped = (work << k) | (work >> k_inv);
      M_ROR:   stepped = (work >> k) | (work << k_inv);
      default: stepped = work;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      mode_q    <= '0;
      remaining <= '0;
      work      <= '0;
      result    <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          work      <= req.data;
          remaining <= req.amt;
          mode_q    <= req.mode;
          busy      <= 1'b1;
          state     <= SHIFT;
        end
        SHIFT: if (remaining != '0) begin
          work      <= stepped;
          remaining <= remaining - k;
        end else begin
          result <= work;
          done   <= 1'b1;
          busy   <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_shift_unit.sv
// Bench for shift_unit: a STEP=1 and a STEP=4 instance sharing operands,
// each with its own start, checked against an arithmetic reference model.
module tb_shift_unit;

  logic              clk = 1'b0;
  logic              reset;
  logic [1:0]        start_v;
  logic [1:0]        src_sel;
  logic [2:0]        mode;
  logic [31:0]       data_in;
  logic [4:0]        reg_b_amt;
  logic [4:0]        shamt;
  logic [31:0]       ext_offset;
  logic [1:0][31:0]  res;
  logic [1:0]        busy_v;
  logic [1:0]        done_v;

  int vectors  = 0;
  int miscomp  = 0;

  always #5 clk = ~clk;

  shift_unit #(.DATA_W(32), .AMT_W(5), .STEP(1)) u1 (
    .clk(clk), .reset(reset), .start(start_v[0]), .src_sel(src_sel), .mode(mode),
    .data_in(data_in), .reg_b_amt(reg_b_amt), .shamt(shamt), .ext_offset(ext_offset),
    .result(res[0]), .busy(busy_v[0]), .done(done_v[0])
  );

  shift_unit #(.DATA_W(32), .AMT_W(5), .STEP(4)) u4 (
    .clk(clk), .reset(reset), .start(start_v[1]), .src_sel(src_sel), .mode(mode),
    .data_in(data_in), .reg_b_amt(reg_b_amt), .shamt(shamt), .ext_offset(ext_offset),
    .result(res[1]), .busy(busy_v[1]), .done(done_v[1])
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscomp++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int step_of(input int d);
    return (d == 0) ? 1 : 4;
  endfunction

  function automatic int model_amt(input logic [2:0] m, input logic [1:0] s,
                                   input logic [4:0] rb, input logic [4:0] sh,
                                   input logic [31:0] ex);
    if (m > 3'd4) return 0;
    case (s)
      2'd0:    return int'(rb);
      2'd1:    return int'(sh);
      2'd2:    return int'(ex[4:0]);
      default: return 0;
    endcase
  endfunction

  function automatic logic [31:0] ref_shift(input logic [2:0] m, input int a,
                                            input logic [31:0] d);
    logic [31:0] r;
    case (m)
      3'd0:    r = d << a;
      3'd1:    r = d >> a;
      3'd2:    r = $signed(d) >>> a;
      3'd3:    r = (a == 0) ? d : ((d << a) | (d >> (32 - a)));
      3'd4:    r = (a == 0) ? d : ((d >> a) | (d << (32 - a)));
      default: r = d;
    endcase
    return r;
  endfunction

  // One full operation on instance d: latency, result, busy and done width.
  task automatic run_op(input int d, input logic [2:0] m, input logic [1:0] s,
                        input logic [31:0] dat, input logic [4:0] rb,
                        input logic [4:0] sh, input logic [31:0] ex);
    int a, lat, n;
    logic [31:0] e;
    a   = model_amt(m, s, rb, sh, ex);
    e   = ref_shift(m, a, dat);
    lat = 1 + (a + step_of(d) - 1) / step_of(d);
    @(negedge clk);
    mode = m; src_sel = s; data_in = dat; reg_b_amt = rb; shamt = sh; ext_offset = ex;
    start_v[d] = 1'b1;
    @(posedge clk); #1;
    start_v[d] = 1'b0;
    chk($sformatf("u%0d_busy_on", d), 32'(busy_v[d]), 32'd1);
    n = 0;
    while (!done_v[d] && n < 60) begin
      @(posedge clk); #1;
      n++;
    end
    chk($sformatf("u%0d_latency m%0d a%0d", d, m, a), n, lat);
    chk($sformatf("u%0d_result m%0d a%0d", d, m, a), res[d], e);
    chk($sformatf("u%0d_busy_off", d), 32'(busy_v[d]), 32'd0);
    @(posedge clk); #1;
    chk($sformatf("u%0d_done_pulse", d), 32'(done_v[d]), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, dones;
    reset = 1'b1; start_v = '0; src_sel = '0; mode = '0; data_in = '0;
    reg_b_amt = '0; shamt = '0; ext_offset = '0;
    #12;
    chk("rst_result_u1", res[0], 32'd0);
    chk("rst_result_u4", res[1], 32'd0);
    chk("rst_busy", 32'(busy_v), 32'd0);
    chk("rst_done", 32'(done_v), 32'd0);
    @(negedge clk); reset = 1'b0;

    // Directed cases
    run_op(0, 3'd0, 2'd1, 32'h0000_0001, 5'd0,  5'd4, 32'd0);
    run_op(0, 3'd2, 2'd0, 32'h8000_0000, 5'd31, 5'd0, 32'd0);
    run_op(0, 3'd1, 2'd0, 32'h8000_0000, 5'd31, 5'd0, 32'd0);
    run_op(1, 3'd4, 2'd2, 32'h1234_5678, 5'd0,  5'd0, 32'h0000_0108);
    run_op(1, 3'd3, 2'd2, 32'h1234_5678, 5'd0,  5'd0, 32'h0000_0108);
    for (int d = 0; d < 2; d++) begin
      run_op(d, 3'd0, 2'd3, 32'hDEAD_BEEF, 5'd7, 5'd7, 32'd7);
      run_op(d, 3'd6, 2'd1, 32'hDEAD_BEEF, 5'd0, 5'd9, 32'd0);
    end
    run_op(1, 3'd0, 2'd1, 32'hFFFF_FFFF, 5'd0, 5'd31, 32'd0);

    // Start held while busy is ignored; start in the done cycle is accepted.
    @(negedge clk);
    mode = 3'd0; src_sel = 2'd1; shamt = 5'd5; data_in = 32'h3; start_v[0] = 1'b1;
    @(posedge clk); #1;
    data_in = 32'hFFFF_0000; shamt = 5'd7; mode = 3'd1; src_sel = 2'd0; reg_b_amt = 5'd2;
    n = 1; dones = 0;
    repeat (3) begin
      @(posedge clk); #1;
      n++;
      if (done_v[0]) dones++;
    end
    start_v[0] = 1'b0;
    n--;
    while (!done_v[0] && n < 60) begin
      @(posedge clk); #1;
      n++;
    end
    chk("held_early_done", dones, 0);
    chk("held_latency", n, 6);
    chk("held_result", res[0], 32'h0000_0060);
    mode = 3'd2; src_sel = 2'd0; reg_b_amt = 5'd4; data_in = 32'h8000_0000; start_v[0] = 1'b1;
    @(posedge clk); #1;
    start_v[0] = 1'b0;
    chk("b2b_done_low", 32'(done_v[0]), 32'd0);
    chk("b2b_busy", 32'(busy_v[0]), 32'd1);
    chk("b2b_result_hold", res[0], 32'h0000_0060);
    n = 0;
    while (!done_v[0] && n < 60) begin
      @(posedge clk); #1;
      n++;
    end
    chk("b2b_latency", n, 5);
    chk("b2b_result", res[0], 32'hF800_0000);

    // Reset in the middle of a 20-bit shift
    @(negedge clk);
    mode = 3'd0; src_sel = 2'd1; shamt = 5'd20; data_in = 32'h0000_00A5; start_v[0] = 1'b1;
    @(posedge clk); #1;
    start_v[0] = 1'b0;
    repeat (9) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    chk("midrst_result", res[0], 32'd0);
    chk("midrst_busy", 32'(busy_v[0]), 32'd0);
    chk("midrst_done", 32'(done_v[0]), 32'd0);
    dones = 0;
    repeat (3) begin
      @(posedge clk); #1;
      if (done_v[0]) dones++;
    end
    @(negedge clk); reset = 1'b0;
    repeat (25) begin
      @(posedge clk); #1;
      if (done_v[0]) dones++;
    end
    chk("midrst_no_done", dones, 0);
    run_op(0, 3'd0, 2'd1, 32'h3, 5'd0, 5'd1, 32'd0);

    // Randomized operations on both instances
    for (int i = 0; i < 25; i++) begin
      for (int d = 0; d < 2; d++) begin
        run_op(d, 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)), $urandom,
               5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), $urandom);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscomp);
    $finish;
  end

endmodule

// File: doc/shift_unit.md
# shift_unit

Parametrised multi-cycle shifter for the datapath's shift instructions. It selects its shift amount from one of three sources: register B, the instruction shamt field, or the sign-extended offset. It performs logical, arithmetic or rotate shifts STEP bits per clock and reports completion with a busy/done handshake so the control unit can stall until the result is ready. The result is held stable until the next accepted start.

## Interface
- DATA_W, 32, operand/result width.
- AMT_W, 5, shift-amount width; must equal log2(DATA_W).
- STEP, 1, maximum bits shifted per clock; power of two, 1..DATA_W.

- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  request; sampled only when busy=0.
- src_sel  in  2  amount source: 0 reg_b_amt, 1 shamt, 2 ext_offset[AMT_W-1:0], 3 constant 0.
- mode  in  3  0 SLL, 1 SRL, 2 SRA, 3 ROL, 4 ROR, 5..7 pass-through (amount forced 0).
- data_in  in  DATA_W  operand.
- reg_b_amt  in  AMT_W  amount from register B.
- shamt  in  AMT_W  instruction shamt field.
- ext_offset  in  32  sign-extended offset; only the low AMT_W bits are used.
- result  out  DATA_W  shifted value; registered.
- busy  out  1  operation in progress.
- done  out  1  one-cycle pulse when result becomes valid.

## Operation
- States: IDLE, SHIFT.
- Outputs are registered.
- IDLE, start=1: capture data_in into the working register and the selected amount into `remaining`, latch mode, go to SHIFT, busy=1.
  - src_sel, mode and data_in are sampled only on the accepting edge. Later changes have no effect on the operation in flight.
- SHIFT, remaining>0: shift the working register by k=min(STEP, remaining) and set remaining -= k.
  - SLL: fill with 0 from the LSB.
  - SRL: fill with 0 from the MSB.
  - SRA: fill with the working register's MSB, replicated.
  - ROL/ROR: rotate bits with wrap-around and no loss.
- SHIFT, remaining==0: copy the working register to result, pulse done=1, clear busy, return to IDLE.
- Amounts are modulo DATA_W by width (max DATA_W-1); no over-range case exists.
- start while busy=1 is ignored, with no queuing.
- start in the same cycle done=1 is accepted, because the state is already IDLE.
- result is unchanged from the done edge until the next done, including while a new operation is busy.
- Reset (any time, including mid-SHIFT): state IDLE, result=0, busy=0, done=0, remaining=0, working register=0. The aborted operation produces no done.

## Timing
- Start accepted at edge k: busy=1 after edge k; done=1 and result valid after edge k+1+ceil(amt/STEP); busy=0 after that same edge.
- Latency in clocks: 1+ceil(amt/STEP).
  - amt=0: 1 clock.
  - STEP=1, amt=31: 32 clocks.
  - STEP=DATA_W: 2 clocks for any nonzero amount.
- done is high for exactly one cycle. It returns to 0 on the following edge, regardless of start.
- Back-to-back ops: the next start may be presented in the done cycle and is accepted on the next edge.
- Reset deassertion: first start accepted on the first rising edge with reset=0.

## Test plan
- STEP=1, mode SLL, src_sel=1, shamt=4, data_in=0x00000001 -> busy for 5 cycles; done at k+5; result=0x00000010.
- STEP=1, mode SRA, src_sel=0, reg_b_amt=31, data_in=0x80000000 -> done at k+32, result=0xFFFFFFFF. Same with SRL -> 0x00000001.
- STEP=4, mode ROR, src_sel=2, ext_offset=0x00000108 (amt 8), data_in=0x12345678 -> done at k+3, result=0x78123456. Same with ROL, amt 8 -> 0x34567812.
- Zero-amount and pass-through, data_in=0xDEADBEEF:
  - src_sel=3 -> done at k+1, result=0xDEADBEEF.
  - mode=6, shamt=9 -> done at k+1, result=0xDEADBEEF.
- Start held high while busy with different data/amount -> ignored: exactly one done and the original result. A start in the done cycle is accepted, and the second result follows its own latency.
- Reset asserted mid-SHIFT (STEP=1, amt=20, cycle 10) -> result, busy and done are 0 immediately with no done pulse. After release, a new SLL by 1 of 0x3 gives result=0x6 at k+2.
